// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, fetch-unit states and instruction field layout.
package cpu_defs;

  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_JZ    = 4'b1001;
  localparam logic [3:0] OP_JC    = 4'b1010;
  localparam logic [3:0] OP_SET   = 4'b1011;
  localparam logic [3:0] OP_HLT   = 4'b1100;
  localparam logic [3:0] OP_PUSH  = 4'b1101;
  localparam logic [3:0] OP_PUSHI = 4'b1110;
  localparam logic [3:0] OP_POP   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Low bit of each 4-bit field inside a 16-bit instruction word.
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned R1_LSB  = 8;
  localparam int unsigned R2_LSB  = 4;
  localparam int unsigned R3_LSB  = 0;

  function automatic logic [3:0] instr_field(input logic [15:0] word, input int unsigned lsb);
    return word[lsb +: 4];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-load bus and issued-instruction bus between the fetch unit and its neighbours.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              prog_we_i;
  logic [ADDR_W-1:0] prog_addr_i;
  logic [15:0]       prog_data_i;
  logic [3:0]        opcode_o;
  logic [3:0]        reg1_o;
  logic [3:0]        reg2_o;
  logic [3:0]        reg3_o;
  logic              valid_o;
  logic [ADDR_W-1:0] pc_o;

  modport master (
    input  prog_we_i, prog_addr_i, prog_data_i,
    output opcode_o, reg1_o, reg2_o, reg3_o, valid_o, pc_o
  );

  modport slave (
    output prog_we_i, prog_addr_i, prog_data_i,
    input  opcode_o, reg1_o, reg2_o, reg3_o, valid_o, pc_o
  );
endinterface

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write, asynchronous read, contents survive reset.
module instr_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);
  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction memory, local resolution of JMP/JZ/JC and HLT.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ZF_BIT     = 0,
  parameter int unsigned CF_BIT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    stall_i,
  input  logic [7:0]              flags_i,
  instr_fetch_unit_if.master      bus,
  output logic                    halted_o
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir;
  logic              valid_q;
  logic              halted_q;
  logic [15:0]       fetch_word;
  logic [3:0]        opc;
  logic [ADDR_W-1:0] target;
  logic              taken;
  logic              mem_we;

  // Loading is locked out while running so a live program cannot be corrupted.
  assign mem_we = bus.prog_we_i && (state != RUN);

  instr_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (IMEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.prog_addr_i),
    .wdata (bus.prog_data_i),
    .raddr (pc),
    .rdata (fetch_word)
  );

  assign opc    = instr_field(ir, OPC_LSB);
  assign target = ADDR_W'({instr_field(ir, R2_LSB), instr_field(ir, R3_LSB)});

  always_comb begin
    taken = 1'b0;
    if (valid_q) begin
      case (opc)
        OP_JMP:  taken = 1'b1;
        OP_JZ:   taken = flags_i[ZF_BIT];
        OP_JC:   taken = flags_i[CF_BIT];
        default: taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      pc_q     <= '0;
      ir       <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start_i) begin
            state    <= RUN;
            pc       <= '0;
            halted_q <= 1'b0;
          end
        end
        RUN: begin
          if (!stall_i) begin
            if (valid_q && opc == OP_HLT) begin
              state    <= HALT;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              // A taken jump squashes the word fetched on this same edge.
              ir      <= fetch_word;
              pc_q    <= pc;
              valid_q <= !taken;
              pc      <= taken ? target : pc + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.opcode_o = instr_field(ir, OPC_LSB);
  assign bus.reg1_o   = instr_field(ir, R1_LSB);
  assign bus.reg2_o   = instr_field(ir, R2_LSB);
  assign bus.reg3_o   = instr_field(ir, R3_LSB);
  assign bus.valid_o  = valid_q;
  assign bus.pc_o     = pc_q;
  assign halted_o     = halted_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized run against a program-level model.
module tb_instr_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_i = 1'b0;
  logic       stall_i = 1'b0;
  logic [7:0] flags_i = 8'h00;
  logic       halted_o;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit_if #(.ADDR_W(8)) bus();

  instr_fetch_unit #(
    .ADDR_W     (8),
    .IMEM_DEPTH (256),
    .ZF_BIT     (0),
    .CF_BIT     (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .stall_i  (stall_i),
    .flags_i  (flags_i),
    .bus      (bus),
    .halted_o (halted_o)
  );

  always #5 clk = ~clk;

  // Program-level model: running or not, next address, and what is currently issued.
  logic [15:0] mm [256];
  bit          m_run;
  logic [7:0]  m_pc;
  logic [7:0]  m_pco;
  logic [15:0] m_ir;
  bit          m_valid;

  task automatic model_reset();
    m_run = 0; m_pc = 8'h00; m_pco = 8'h00; m_ir = 16'h0000; m_valid = 0;
  endtask

  task automatic model_edge(input bit st, input bit stl, input bit we,
                            input logic [7:0] a, input logic [15:0] d, input logic [7:0] fl);
    logic [3:0] op;
    bit tk;
    if (!m_run) begin
      if (we) mm[a] = d;
      if (st) begin m_run = 1; m_pc = 8'h00; end
    end else if (!stl) begin
      op = m_ir[15:12];
      if (m_valid && op == 4'hC) begin
        m_run = 0; m_valid = 0;
      end else begin
        tk = m_valid && (op == 4'h8 || (op == 4'h9 && fl[0]) || (op == 4'hA && fl[1]));
        m_pco   = m_pc;
        m_valid = !tk;
        m_pc    = tk ? m_ir[7:0] : 8'((int'(m_pc) + 1) % 256);
        m_ir    = mm[m_pco];
      end
    end
  endtask

  task automatic step(input bit st = 0, input bit stl = 0, input bit we = 0,
                      input logic [7:0] a = 8'h00, input logic [15:0] d = 16'h0000);
    @(negedge clk);
    start_i = st; stall_i = stl;
    bus.prog_we_i = we; bus.prog_addr_i = a; bus.prog_data_i = d;
    @(posedge clk);
    model_edge(st, stl, we, a, d, flags_i);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    step(0, 0, 1, a, d);
  endtask

  function automatic logic [25:0] dut_vec();
    return {halted_o, bus.valid_o, bus.pc_o, bus.opcode_o, bus.reg1_o, bus.reg2_o, bus.reg3_o};
  endfunction

  function automatic logic [25:0] model_vec();
    return {!m_run, m_valid, m_pco, m_ir};
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({halted_o, bus.valid_o, bus.pc_o, bus.opcode_o} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
      errors++;
      $display("FAIL reset: got halted=%b valid=%b pc=%h op=%h want 1 0 00 0",
               halted_o, bus.valid_o, bus.pc_o, bus.opcode_o);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_load_halt();
    load(8'h00, 16'hB123);
    load(8'h01, 16'hC000);
    step(1);
    step();
    checks++;
    if ({bus.opcode_o, bus.reg1_o, bus.reg2_o, bus.reg3_o, bus.valid_o, bus.pc_o, halted_o}
        !== {4'hB, 4'h1, 4'h2, 4'h3, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL first_issue: got op=%h r=%h%h%h valid=%b pc=%h halted=%b want B 123 1 00 0",
               bus.opcode_o, bus.reg1_o, bus.reg2_o, bus.reg3_o, bus.valid_o, bus.pc_o, halted_o);
    end
    step();
    checks++;
    if ({bus.opcode_o, bus.valid_o, bus.pc_o} !== {4'hC, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL hlt_issue: got op=%h valid=%b pc=%h want C 1 01", bus.opcode_o, bus.valid_o, bus.pc_o);
    end
    step();
    checks++;
    if ({halted_o, bus.valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL halt_entry: got halted=%b valid=%b want 1 0", halted_o, bus.valid_o);
    end
  endtask

  task automatic test_jmp();
    load(8'h00, 16'h8040);
    load(8'h40, 16'h2345);
    load(8'h41, 16'hC000);
    step(1);
    step();
    checks++;
    if ({bus.opcode_o, bus.valid_o, bus.pc_o} !== {4'h8, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL jmp_issue: got op=%h valid=%b pc=%h want 8 1 00", bus.opcode_o, bus.valid_o, bus.pc_o);
    end
    step();
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL jmp_bubble: got valid=%b want 0", bus.valid_o);
    end
    step();
    checks++;
    if ({bus.opcode_o, bus.reg3_o, bus.valid_o, bus.pc_o} !== {4'h2, 4'h5, 1'b1, 8'h40}) begin
      errors++;
      $display("FAIL jmp_target: got op=%h r3=%h valid=%b pc=%h want 2 5 1 40",
               bus.opcode_o, bus.reg3_o, bus.valid_o, bus.pc_o);
    end
    step();
    step();
    checks++;
    if (halted_o !== 1'b1) begin
      errors++;
      $display("FAIL jmp_halt: got halted=%b want 1", halted_o);
    end
  endtask

  task automatic test_cond_jumps();
    logic [15:0] words [3] = '{16'h9010, 16'h9010, 16'hA010};
    logic [7:0]  fls   [3] = '{8'h01, 8'h00, 8'h02};
    bit          tks   [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      load(8'h00, words[i]);
      load(8'h01, 16'hC000);
      load(8'h10, 16'hC000);
      flags_i = fls[i];
      step(1);
      step();
      step();
      checks++;
      if (tks[i] ? (bus.valid_o !== 1'b0) : ({bus.valid_o, bus.pc_o} !== {1'b1, 8'h01})) begin
        errors++;
        $display("FAIL cond_jump%0d: got valid=%b pc=%h want taken=%0d", i, bus.valid_o, bus.pc_o, tks[i]);
      end
      if (tks[i]) begin
        step();
        checks++;
        if ({bus.valid_o, bus.pc_o} !== {1'b1, 8'h10}) begin
          errors++;
          $display("FAIL cond_target%0d: got valid=%b pc=%h want 1 10", i, bus.valid_o, bus.pc_o);
        end
      end
      step();
      flags_i = 8'h00;
    end
  endtask

  task automatic test_stall();
    logic [15:0] prog [7];
    for (int i = 0; i < 6; i++) prog[i] = 16'h1000 + 16'(i);
    prog[6] = 16'hC000;
    for (int i = 0; i < 7; i++) load(8'(i), prog[i]);
    step(1);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      checks++;
      if ({bus.opcode_o, bus.reg3_o, bus.valid_o, bus.pc_o} !== {4'h1, 4'h1, 1'b1, 8'h01}) begin
        errors++;
        $display("FAIL stall_hold%0d: got op=%h r3=%h valid=%b pc=%h want 1 1 1 01",
                 i, bus.opcode_o, bus.reg3_o, bus.valid_o, bus.pc_o);
      end
    end
    for (int k = 2; k < 7; k++) begin
      step();
      checks++;
      if ({bus.opcode_o, bus.reg3_o, bus.valid_o, bus.pc_o} !== {prog[k][15:12], prog[k][3:0], 1'b1, 8'(k)}) begin
        errors++;
        $display("FAIL stall_resume%0d: got op=%h r3=%h valid=%b pc=%h want %h %h 1 %h",
                 k, bus.opcode_o, bus.reg3_o, bus.valid_o, bus.pc_o, prog[k][15:12], prog[k][3:0], k);
      end
    end
    step();
  endtask

  task automatic test_wrap_protect();
    load(8'h00, 16'h90FF);
    load(8'h01, 16'hC000);
    load(8'hFF, 16'h3000);
    load(8'h80, 16'h4444);
    flags_i = 8'h01;
    step(1);
    step();
    step();
    step(0, 0, 1, 8'h80, 16'hFFFF);
    checks++;
    if ({bus.valid_o, bus.pc_o, bus.opcode_o} !== {1'b1, 8'hFF, 4'h3}) begin
      errors++;
      $display("FAIL wrap_ff: got valid=%b pc=%h op=%h want 1 FF 3", bus.valid_o, bus.pc_o, bus.opcode_o);
    end
    step(0, 0, 1, 8'h80, 16'hFFFF);
    checks++;
    if ({bus.valid_o, bus.pc_o, bus.opcode_o} !== {1'b1, 8'h00, 4'h9}) begin
      errors++;
      $display("FAIL wrap_00: got valid=%b pc=%h op=%h want 1 00 9", bus.valid_o, bus.pc_o, bus.opcode_o);
    end
    flags_i = 8'h00;
    step();
    step();
    load(8'h00, 16'h8080);
    load(8'h81, 16'hC000);
    step(1);
    step();
    step();
    step();
    checks++;
    if ({bus.valid_o, bus.pc_o, bus.opcode_o, bus.reg1_o, bus.reg3_o} !== {1'b1, 8'h80, 4'h4, 4'h4, 4'h4}) begin
      errors++;
      $display("FAIL write_protect: got valid=%b pc=%h op=%h r1=%h r3=%h want 1 80 4 4 4",
               bus.valid_o, bus.pc_o, bus.opcode_o, bus.reg1_o, bus.reg3_o);
    end
    step();
    step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) load(8'(i), 16'h5000 + 16'(i));
    load(8'h04, 16'hC000);
    step(1);
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({halted_o, bus.valid_o, bus.pc_o, bus.opcode_o} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
      errors++;
      $display("FAIL async_reset: got halted=%b valid=%b pc=%h op=%h want 1 0 00 0",
               halted_o, bus.valid_o, bus.pc_o, bus.opcode_o);
    end
    #1 rst_n = 1'b1;
    step(1);
    step();
    checks++;
    if ({bus.valid_o, bus.pc_o, bus.opcode_o, bus.reg3_o} !== {1'b1, 8'h00, 4'h5, 4'h0}) begin
      errors++;
      $display("FAIL restart0: got valid=%b pc=%h op=%h r3=%h want 1 00 5 0",
               bus.valid_o, bus.pc_o, bus.opcode_o, bus.reg3_o);
    end
    step();
    checks++;
    if ({bus.valid_o, bus.pc_o, bus.opcode_o, bus.reg3_o} !== {1'b1, 8'h01, 4'h5, 4'h1}) begin
      errors++;
      $display("FAIL restart1: got valid=%b pc=%h op=%h r3=%h want 1 01 5 1",
               bus.valid_o, bus.pc_o, bus.opcode_o, bus.reg3_o);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (halted_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_halt: got halted=%b want 1", halted_o);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int a = 0; a < 256; a++) load(8'(a), 16'($urandom));
    for (int c = 0; c < 1500; c++) begin
      flags_i = 8'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           8'($urandom), 16'($urandom));
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle%0d: got halted/valid/pc/ir=%h want %h", c, dut_vec(), model_vec());
        bad++;
      end
    end
  endtask

  initial begin
    bus.prog_we_i = 1'b0;
    bus.prog_addr_i = 8'h00;
    bus.prog_data_i = 16'h0000;
    test_reset();
    test_load_halt();
    test_jmp();
    test_cond_jumps();
    test_stall();
    test_wrap_protect();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
